// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

   // Arbiter sequencing: pick a winner, acknowledge it, kick the tx core, wait for the frame
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCEPT    = 2'd1,
      START     = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

   localparam int DEF_NUM_REQ     = 4;
   localparam int DEF_DATA_W      = 8;
   localparam int DEF_TIMEOUT_CYC = 200000;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection: first valid requester scanning from rr_ptr upward, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic               any_valid,
   output logic [ID_W-1:0]    winner
);

   // Scan offsets from farthest to nearest so the closest valid index to rr_ptr is assigned last and wins
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[ID_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
            any_valid = 1'b1;
            winner    = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx core among NUM_REQ byte producers, round-robin, one byte per grant, with a frame watchdog.
// Latency: req_valid seen in IDLE -> req_ready +1 cycle -> tx_start +2 cycles; >= 4 cycles between tx_start pulses.
// Backpressure: requesters hold valid/data until their req_ready pulse; the tx core is paced by tx_start/tx_done.
// Optional feature macro: UART_ARB_LOCK_EN (sticky grant while req_lock of the granted requester is high).
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ     = DEF_NUM_REQ,
   parameter  int DATA_W      = DEF_DATA_W,
   parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int ID_W        = $clog2(NUM_REQ),
   localparam int CNT_W       = $clog2(TIMEOUT_CYC)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_lock,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_done,
   output logic [ID_W-1:0]           grant_id,
   output logic                      arb_busy,
   output logic                      tmo_err
);

   // Counter holds CNT_SAT in the cycle tmo_err is visible; the expiry decision is taken one value earlier
   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(TIMEOUT_CYC - 2);

   arb_state_t        state;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  wd_cnt;
   logic              any_valid;
   logic [ID_W-1:0]   winner;
   logic [ID_W-1:0]   next_ptr;
   logic [ID_W-1:0]   done_ptr;
   logic [DATA_W-1:0] req_bytes [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
      assign req_bytes[i] = req_data[i*DATA_W +: DATA_W];
   end

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .any_valid (any_valid),
      .winner    (winner)
   );

   // Requester after the current grant, wrapping explicitly so non-power-of-two NUM_REQ works
   assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef UART_ARB_LOCK_EN
   // A locked requester keeps the pointer on itself, so it wins again if still valid
   assign done_ptr = req_lock[grant_id] ? grant_id : next_ptr;
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign done_ptr    = next_ptr;
`endif

   // Arbitration FSM with registered outputs, round-robin pointer and frame watchdog
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         wd_cnt    <= '0;
         req_ready <= '0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         grant_id  <= '0;
         arb_busy  <= 1'b0;
         tmo_err   <= 1'b0;
      end else begin
         req_ready <= '0;
         tx_start  <= 1'b0;
         tmo_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_id  <= winner;
                  tx_data   <= req_bytes[winner];
                  req_ready <= NUM_REQ'(1) << winner;
                  arb_busy  <= 1'b1;
                  state     <= ACCEPT;
               end
            end
            ACCEPT: begin
               tx_start <= 1'b1;
               state    <= START;
            end
            START: begin
               wd_cnt <= '0;
               state  <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (tx_done) begin
                  rr_ptr   <= done_ptr;
                  arb_busy <= 1'b0;
                  state    <= IDLE;
               end else begin
                  if (wd_cnt != CNT_SAT) begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
                  if (wd_cnt == CNT_EXPIRE) begin
                     // Timeout always advances, breaking any lock
                     tmo_err  <= 1'b1;
                     rr_ptr   <= next_ptr;
                     arb_busy <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: begin
               arb_busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8, TIMEOUT_CYC=16).
// Grants are checked against a vector table; tx bytes go through a scoreboard queue.
// Hand sequences cover watchdog expiry, done/expiry race, async reset and grant lock.
module tb_uart_tx_arbiter;

   localparam logic [31:0] BYTES_A = 32'hA3A2A1A0;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_lock;
   logic [3:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_done;
   logic [1:0]  grant_id;
   logic        arb_busy;
   logic        tmo_err;

   int checks = 0;
   int errors = 0;
   logic [9:0] sb_q [$];

   typedef struct {
      logic [3:0]  v;
      logic [31:0] d;
      logic [1:0]  id;
      logic [7:0]  byte_exp;
   } vec_t;
   vec_t tbl [12];

   uart_tx_arbiter #(
      .NUM_REQ     (4),
      .DATA_W      (8),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_done   (tx_done),
      .grant_id  (grant_id),
      .arb_busy  (arb_busy),
      .tmo_err   (tmo_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every tx_start must match the oldest expected {grant_id, byte}
   always @(negedge clk) begin
      if (tx_start === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: tx_start with id %0d data %0h, nothing expected", grant_id, tx_data);
         end else begin
            logic [9:0] e;
            e = sb_q.pop_front();
            if ({grant_id, tx_data} !== e) begin
               errors++;
               $display("FAIL sb_byte: got id %0d data %0h expected id %0d data %0h",
                        grant_id, tx_data, e[9:8], e[7:0]);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (arb_busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL idle_wait: arb_busy still %b after 50 cycles", arb_busy);
      end
   endtask

   // One complete grant: drive request, check latency, answer with tx_done after 3 cycles
   task automatic do_txn(input logic [3:0] v, input logic [31:0] d, input logic [3:0] lk,
                         input logic [1:0] exp_id, input logic [7:0] exp_byte);
      wait_idle();
      req_valid = v;
      req_data  = d;
      req_lock  = lk;
      sb_q.push_back({exp_id, exp_byte});
      @(negedge clk);
      chk("req_ready", 32'(req_ready), 32'(4'b0001 << exp_id));
      chk("busy_accept", 32'(arb_busy), 32'd1);
      req_valid = '0;
      @(negedge clk);
      chk("tx_start_lat", 32'(tx_start), 32'd1);
      repeat (3) @(negedge clk);
      chk("tx_data_hold", 32'(tx_data), 32'(exp_byte));
      chk("tx_start_pulse", 32'(tx_start), 32'd0);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("busy_after_done", 32'(arb_busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      reset     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_lock  = '0;
      tx_done   = 1'b0;

      tbl[0]  = '{4'b0100, 32'h0041_0000, 2'd2, 8'h41};
      tbl[1]  = '{4'b1000, BYTES_A, 2'd3, 8'hA3};
      tbl[2]  = '{4'b1111, BYTES_A, 2'd0, 8'hA0};
      tbl[3]  = '{4'b1111, BYTES_A, 2'd1, 8'hA1};
      tbl[4]  = '{4'b1111, BYTES_A, 2'd2, 8'hA2};
      tbl[5]  = '{4'b1111, BYTES_A, 2'd3, 8'hA3};
      tbl[6]  = '{4'b1111, BYTES_A, 2'd0, 8'hA0};
      tbl[7]  = '{4'b0001, BYTES_A, 2'd0, 8'hA0};
      tbl[8]  = '{4'b1001, BYTES_A, 2'd3, 8'hA3};
      tbl[9]  = '{4'b0001, BYTES_A, 2'd0, 8'hA0};
      tbl[10] = '{4'b0110, BYTES_A, 2'd1, 8'hA1};
      tbl[11] = '{4'b0011, BYTES_A, 2'd0, 8'hA0};

      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_arb_busy", 32'(arb_busy), 32'd0);
      chk("rst_tmo_err", 32'(tmo_err), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         do_txn(tbl[i].v, tbl[i].d, 4'b0000, tbl[i].id, tbl[i].byte_exp);
      end

      // tx_done while idle must not start anything
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      @(negedge clk);
      chk("idle_done_busy", 32'(arb_busy), 32'd0);
      chk("idle_done_start", 32'(tx_start), 32'd0);

      // Watchdog expiry: no tx_done, tmo_err 16 cycles after tx_start
      wait_idle();
      req_valid = 4'b0100;
      req_data  = BYTES_A;
      sb_q.push_back({2'd2, 8'hA2});
      @(negedge clk);
      chk("tmo_ready", 32'(req_ready), 32'b0100);
      req_valid = '0;
      @(negedge clk);
      chk("tmo_tx_start", 32'(tx_start), 32'd1);
      n = 0;
      while (tmo_err !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_latency", 32'(n), 32'd16);
      @(negedge clk);
      chk("tmo_pulse_len", 32'(tmo_err), 32'd0);
      chk("tmo_busy", 32'(arb_busy), 32'd0);

      // tx_done in the expiry cycle: done wins, no tmo_err
      req_valid = 4'b1000;
      sb_q.push_back({2'd3, 8'hA3});
      @(negedge clk);
      chk("race_ready", 32'(req_ready), 32'b1000);
      req_valid = '0;
      @(negedge clk);
      chk("race_tx_start", 32'(tx_start), 32'd1);
      repeat (15) @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      chk("race_no_tmo", 32'(tmo_err), 32'd0);
      chk("race_busy", 32'(arb_busy), 32'd0);
      @(negedge clk);
      chk("race_no_tmo_late", 32'(tmo_err), 32'd0);

      // Move rr_ptr away from 0, then reset mid-frame
      do_txn(4'b0010, BYTES_A, 4'b0000, 2'd1, 8'hA1);
      wait_idle();
      req_valid = 4'b0100;
      sb_q.push_back({2'd2, 8'hA2});
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("arst_tx_start", 32'(tx_start), 32'd0);
      chk("arst_req_ready", 32'(req_ready), 32'd0);
      chk("arst_busy", 32'(arb_busy), 32'd0);
      chk("arst_tx_data", 32'(tx_data), 32'd0);
      chk("arst_grant_id", 32'(grant_id), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      do_txn(4'b1111, BYTES_A, 4'b0000, 2'd0, 8'hA0);

      // Grant lock on requester 1 (ignored in the plain round-robin build)
      do_txn(4'b0011, BYTES_A, 4'b0010, 2'd1, 8'hA1);
`ifdef UART_ARB_LOCK_EN
      do_txn(4'b0011, BYTES_A, 4'b0010, 2'd1, 8'hA1);
`else
      do_txn(4'b0011, BYTES_A, 4'b0010, 2'd0, 8'hA0);
`endif
      do_txn(4'b0011, BYTES_A, 4'b0000, 2'd1, 8'hA1);
      do_txn(4'b0011, BYTES_A, 4'b0000, 2'd0, 8'hA0);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
